// File: rtl/wishbone_ram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_ram_slave_if
//  Description : Wishbone classic bus bundle between one interconnect slave
//                port and the RAM slave; ms_* travel toward the slave,
//                sm_* travel back toward the interconnect.
//  Revision    : 1.0  initial release
// ============================================================================
interface wishbone_ram_slave_if #(
  parameter int TAGSIZE = 1
);
  logic [31:0]        ms_dat_i;
  logic [TAGSIZE-1:0] ms_tgd_i;
  logic [31:0]        ms_adr_i;
  logic [TAGSIZE-1:0] ms_tga_i;
  logic               ms_cyc_i;
  logic [TAGSIZE-1:0] ms_tgc_i;
  logic [3:0]         ms_sel_i;
  logic               ms_stb_i;
  logic               ms_we_i;
  logic [31:0]        sm_dat_o;
  logic [TAGSIZE-1:0] sm_tgd_o;
  logic               sm_ack_o;
  logic               sm_err_o;
  logic               sm_rty_o;

  modport slave (
    input  ms_dat_i, ms_tgd_i, ms_adr_i, ms_tga_i, ms_cyc_i,
           ms_tgc_i, ms_sel_i, ms_stb_i, ms_we_i,
    output sm_dat_o, sm_tgd_o, sm_ack_o, sm_err_o, sm_rty_o
  );

  modport master (
    output ms_dat_i, ms_tgd_i, ms_adr_i, ms_tga_i, ms_cyc_i,
           ms_tgc_i, ms_sel_i, ms_stb_i, ms_we_i,
    input  sm_dat_o, sm_tgd_o, sm_ack_o, sm_err_o, sm_rty_o
  );
endinterface
`default_nettype wire

// File: rtl/wishbone_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_ram_slave
//  Description : Wishbone classic single-port RAM slave. 32-bit word reads,
//                byte-masked writes, configurable wait states, error answer
//                for misaligned or out-of-range slave-relative addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module wishbone_ram_slave #(
  parameter int TAGSIZE     = 1,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  wire                        clk_i,
  input  wire                        rst_i,
  wishbone_ram_slave_if.slave        bus
);

  localparam int          c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  c_CNT0  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_err;
  logic [c_AW-1:0]    r_idx;
  logic [31:0]        r_wdat;
  logic [3:0]         r_sel;
  logic               r_we;
  logic [TAGSIZE-1:0] r_tgd;
  logic [31:0]        r_rdat;
  logic [31:0]        r_mem [DEPTH];

  logic               w_req;
  logic               w_bad;
  logic [c_AW-1:0]    w_in_idx;
  logic               w_unused;

  assign w_req    = bus.ms_cyc_i & bus.ms_stb_i;
  // The range compare sees the full 32-bit address, so high garbage bits
  // are rejected rather than aliased onto the array.
  assign w_bad    = (bus.ms_adr_i[1:0] != 2'b00) | (bus.ms_adr_i >= c_LIMIT);
  assign w_in_idx = bus.ms_adr_i[c_AW+1:2];
  // Address and write-data tags carry nothing this slave needs.
  assign w_unused = ^{bus.ms_tga_i, bus.ms_tgd_i};

  // Transfer sequencing: accept, optional wait countdown, one-cycle response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdat  <= 32'd0;
      r_sel   <= 4'd0;
      r_we    <= 1'b0;
      r_tgd   <= '0;
      r_rdat  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx  <= w_in_idx;
            r_wdat <= bus.ms_dat_i;
            r_sel  <= bus.ms_sel_i;
            r_we   <= bus.ms_we_i;
            r_tgd  <= bus.ms_tgc_i;
            if (w_bad) begin
              // Errors answer immediately, ignoring the wait-state setting.
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_rdat  <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_err   <= 1'b0;
              r_rdat  <= bus.ms_we_i ? 32'd0 : r_mem[w_in_idx];
            end else begin
              r_state <= S_WAIT;
              r_err   <= 1'b0;
              r_cnt   <= c_CNT0;
            end
          end
        end
        S_WAIT: begin
          if (!bus.ms_cyc_i) begin
            // Master abandoned the cycle: drop it silently.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            r_rdat  <= r_we ? 32'd0 : r_mem[r_idx];
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Write commit on the closing edge of the response cycle, per byte lane.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (r_state == S_RESP) && r_we && !r_err && bus.ms_cyc_i) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k]) begin
          r_mem[r_idx][8*k +: 8] <= r_wdat[8*k +: 8];
        end
      end
    end
  end

  assign bus.sm_dat_o = r_rdat;
  assign bus.sm_tgd_o = r_tgd;
  assign bus.sm_ack_o = (r_state == S_RESP) & ~r_err & bus.ms_cyc_i;
  assign bus.sm_err_o = (r_state == S_RESP) &  r_err & bus.ms_cyc_i;
  assign bus.sm_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_ram_slave
//  Description : Directed self-checking bench; two slaves, one with no wait
//                states and one with three.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wishbone_ram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-slave drive (index 0: no waits, index 1: three waits)
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [3:0]  sel [2];
  logic [3:0]  tgc [2];

  logic        ack_w [2];
  logic        err_w [2];
  logic        rty_w [2];
  logic [31:0] dat_w [2];
  logic [3:0]  tgd_w [2];

  wishbone_ram_slave_if #(.TAGSIZE(4)) if0 ();
  wishbone_ram_slave_if #(.TAGSIZE(4)) if3 ();

  assign if0.ms_cyc_i = cyc[0];  assign if3.ms_cyc_i = cyc[1];
  assign if0.ms_stb_i = stb[0];  assign if3.ms_stb_i = stb[1];
  assign if0.ms_we_i  = we[0];   assign if3.ms_we_i  = we[1];
  assign if0.ms_adr_i = adr[0];  assign if3.ms_adr_i = adr[1];
  assign if0.ms_dat_i = wd[0];   assign if3.ms_dat_i = wd[1];
  assign if0.ms_sel_i = sel[0];  assign if3.ms_sel_i = sel[1];
  assign if0.ms_tgc_i = tgc[0];  assign if3.ms_tgc_i = tgc[1];
  assign if0.ms_tga_i = 4'h0;    assign if3.ms_tga_i = 4'h0;
  assign if0.ms_tgd_i = 4'h0;    assign if3.ms_tgd_i = 4'h0;

  assign ack_w[0] = if0.sm_ack_o;  assign ack_w[1] = if3.sm_ack_o;
  assign err_w[0] = if0.sm_err_o;  assign err_w[1] = if3.sm_err_o;
  assign rty_w[0] = if0.sm_rty_o;  assign rty_w[1] = if3.sm_rty_o;
  assign dat_w[0] = if0.sm_dat_o;  assign dat_w[1] = if3.sm_dat_o;
  assign tgd_w[0] = if0.sm_tgd_o;  assign tgd_w[1] = if3.sm_tgd_o;

  wishbone_ram_slave #(.TAGSIZE(4), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  wishbone_ram_slave #(.TAGSIZE(4), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, " ack"}, 32'(ack_w[d]), 32'd0);
    check({tag, " err"}, 32'(err_w[d]), 32'd0);
    check({tag, " rty"}, 32'(rty_w[d]), 32'd0);
    check({tag, " dat"}, dat_w[d], 32'd0);
    check({tag, " tgd"}, 32'(tgd_w[d]), 32'd0);
  endtask

  // One full transfer; lat = cycles after the accept edge before the response.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] data, input logic [3:0] s,
                      input logic [3:0] t, input int lat, input logic exp_err,
                      input logic chk_dat, input logic [31:0] exp_dat,
                      input string tag);
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a;
    wd[d] = data; sel[d] = s; tgc[d] = t;
    @(posedge clk); #1;               // accept edge
    stb[d] = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check({tag, " ack"}, 32'(ack_w[d]), 32'((i == lat) && !exp_err));
      check({tag, " err"}, 32'(err_w[d]), 32'((i == lat) && exp_err));
      check({tag, " rty"}, 32'(rty_w[d]), 32'd0);
      if (i == lat) begin
        if (chk_dat) check({tag, " dat"}, dat_w[d], exp_dat);
        check({tag, " tgd"}, 32'(tgd_w[d]), 32'(t));
      end
      @(posedge clk); #1;
    end
    cyc[d] = 1'b0; we[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'd0;
      wd[d] = 32'd0; sel[d] = 4'd0; tgc[d] = 4'd0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst3");

    // No wait states: full write, read back
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'h1, 0, 1'b0, 1'b1, 32'h0, "w0_full");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 4'h2, 0, 1'b0, 1'b1, 32'hDEADBEEF, "r0_full");

    // Byte lane 1 only
    xfer(0, 1'b1, 32'h10, 32'h00001200, 4'h2, 4'h3, 0, 1'b0, 1'b1, 32'h0, "w0_lane");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 4'h4, 0, 1'b0, 1'b1, 32'hDEAD12EF, "r0_lane");

    // Empty select acks without touching the word
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 4'h5, 0, 1'b0, 1'b1, 32'h0, "w0_nosel");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 4'h6, 0, 1'b0, 1'b1, 32'hDEAD12EF, "r0_nosel");

    // Errors: out of range read, misaligned write, word 0 untouched
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, 4'h7, 0, 1'b0, 1'b1, 32'h0, "w0_word0");
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 4'h8, 0, 1'b1, 1'b1, 32'h0, "e0_range");
    xfer(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 4'h9, 0, 1'b1, 1'b1, 32'h0, "e0_misal");
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 4'hA, 0, 1'b0, 1'b1, 32'h11223344, "r0_word0");
    xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 4'hB, 0, 1'b0, 1'b0, 32'h0, "r0_last");

    // Three wait states; error still answers after one cycle
    xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 4'h1, 3, 1'b0, 1'b1, 32'h0, "w3");
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 4'h5, 3, 1'b0, 1'b1, 32'hCAFEF00D, "r3_tg5");
    xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF, 4'h6, 0, 1'b1, 1'b1, 32'h0, "e3_range");

    // Abort: cyc drops during the second wait cycle
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20;
    wd[1] = 32'h0; sel[1] = 4'hF; tgc[1] = 4'h2;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(negedge clk);
    check("abort w1 ack", 32'(ack_w[1]), 32'd0);
    @(posedge clk); #1;
    cyc[1] = 1'b0; we[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort ack", 32'(ack_w[1]), 32'd0);
      check("abort err", 32'(err_w[1]), 32'd0);
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 4'h3, 3, 1'b0, 1'b1, 32'hCAFEF00D, "r3_abort");

    // Reset during a wait cycle
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h20; tgc[1] = 4'h7;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs(1, "rst_mid");
    @(posedge clk); #1;
    cyc[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid ack", 32'(ack_w[1]), 32'd0);
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 4'h4, 3, 1'b0, 1'b1, 32'hCAFEF00D, "r3_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
